char_buffer_writer: RTL

- Text-buffer owner for the VGA character overlay pipeline.
- Write side: accepts character bytes over a valid/ready stream from status logic, with cursor tracking and control-character handling.
- Read side: answers the overlay's char_xy / char_line requests with a registered font-ROM address (character code concatenated with line).
- Position: between the status/text source and the font ROM that returns char_pixel to the overlay.

---
 rtl/char_buffer_writer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/char_buffer_writer.sv
// char_buffer_writer
//
// Owns the text buffer behind the VGA character overlay.
//
// Write side: a valid/ready byte stream from the status logic. The block
// tracks a cursor and interprets LF, CR and BS. Printable bytes land at the
// cursor, which then advances. After reset, and on every cmd_clear, the whole
// buffer is first filled with FILL_CHAR, one cell per clock.
//
// Read side: the overlay presents char_xy / char_line every pixel clock. One
// cycle later font_addr = {code[6:0], char_line} is presented to the font ROM.
//
// Ports
//   clk        pixel clock
//   rst        asynchronous, active-high reset
//   wr_valid   character byte valid
//   wr_char    character byte (ASCII)
//   wr_ready   byte accepted this cycle (high whenever no clear is running)
//   cmd_clear  single-cycle pulse: clear buffer, cursor home
//   cursor     current write address {row[3:0], col[3:0]}
//   char_xy    overlay read address {row[3:0], col[3:0]}
//   char_line  overlay glyph line
//   font_addr  registered font ROM address {char_code[6:0], char_line}
//   busy       clear sequence in progress
module char_buffer_writer #(
    parameter int         COLS      = 16,
    parameter int         ROWS      = 16,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [7:0]  wr_char,
    output logic        wr_ready,
    input  logic        cmd_clear,
    output logic [7:0]  cursor,
    input  logic [7:0]  char_xy,
    input  logic [3:0]  char_line,
    output logic [10:0] font_addr,
    output logic        busy
);

    localparam logic [3:0] COL_MAX = 4'(COLS - 1);
    localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
    localparam logic [4:0] COLS_L  = 5'(COLS);
    localparam logic [4:0] ROWS_L  = 5'(ROWS);
    localparam logic [6:0] FILL7   = FILL_CHAR[6:0];

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  clr_cnt_q, clr_cnt_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [10:0] font_addr_q, font_addr_d;

    // Bit 7 of a stored byte is never used on the read side, and printable
    // codes never have it set, so only the 7-bit code field is kept.
    logic [6:0]  mem_q [256];

    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [6:0]  mem_wdata;
    logic        mem_we_ok;
    logic [6:0]  rd_code;
    logic        byte_acc;

    // Cells outside the ROWS x COLS window exist in the address space only.
    function automatic logic addr_ok(input logic [7:0] a);
        return ({1'b0, a[7:4]} < ROWS_L) && ({1'b0, a[3:0]} < COLS_L);
    endfunction

    function automatic logic [3:0] row_inc(input logic [3:0] r);
        return (r == ROW_MAX) ? 4'd0 : r + 4'd1;
    endfunction

    assign wr_ready  = (state_q == IDLE);
    assign busy      = (state_q == CLEAR);
    assign cursor    = {row_q, col_q};
    assign font_addr = font_addr_q;
    assign byte_acc  = wr_valid && wr_ready;

    // ------------------------------------------------------------------
    // Read path: combinational buffer read, registered ROM address. The
    // array still holds pre-edge contents here, so a same-cycle write to
    // the same cell shows up one read later.
    // ------------------------------------------------------------------
    always_comb begin
        rd_code     = addr_ok(char_xy) ? mem_q[char_xy] : FILL7;
        font_addr_d = {rd_code, char_line};
    end

    // ------------------------------------------------------------------
    // FSM next-state, cursor and write-port control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        mem_we    = 1'b0;
        mem_waddr = {row_q, col_q};
        mem_wdata = FILL7;

        unique case (state_q)
            CLEAR: begin
                if (cmd_clear) begin
                    clr_cnt_d = 8'd0;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_cnt_q;
                    clr_cnt_d = clr_cnt_q + 8'd1;
                    if (clr_cnt_q == 8'hFF) begin
                        state_d = IDLE;
                        row_d   = 4'd0;
                        col_d   = 4'd0;
                    end
                end
            end

            IDLE: begin
                if (cmd_clear) begin
                    // Clear wins over a byte offered in the same cycle; that
                    // byte is consumed (wr_ready is high) and dropped.
                    state_d   = CLEAR;
                    clr_cnt_d = 8'd0;
                    row_d     = 4'd0;
                    col_d     = 4'd0;
                end else if (byte_acc) begin
                    if (wr_char == CH_LF) begin
                        col_d = 4'd0;
                        row_d = row_inc(row_q);
                    end else if (wr_char == CH_CR) begin
                        col_d = 4'd0;
                    end else if (wr_char == CH_BS) begin
                        // Erase the cell we step back onto; no wrap to the
                        // previous row.
                        if (col_q != 4'd0) begin
                            col_d     = col_q - 4'd1;
                            mem_we    = 1'b1;
                            mem_waddr = {row_q, col_q - 4'd1};
                            mem_wdata = FILL7;
                        end
                    end else if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
                        mem_we    = 1'b1;
                        mem_waddr = {row_q, col_q};
                        mem_wdata = wr_char[6:0];
                        if (col_q == COL_MAX) begin
                            col_d = 4'd0;
                            row_d = row_inc(row_q);
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end
                    // any other code: accepted and ignored
                end
            end

            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // The clear counter sweeps every address; out-of-window cells are masked.
    assign mem_we_ok = mem_we && addr_ok(mem_waddr);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= 8'd0;
            row_q       <= 4'd0;
            col_q       <= 4'd0;
            font_addr_q <= 11'd0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            font_addr_q <= font_addr_d;
        end
    end

    // Buffer array: no reset, the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (mem_we_ok) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule
